// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial WIDTH-bit add/subtract built around one full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_r;
  logic [CW-1:0] cnt;
  logic carry, co_r, v_r, fa_s, fa_co, last;
  full_adder fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(fa_s), .co(fa_co));
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  assign S    = s_r;
  assign Co   = co_r;
  assign V    = v_r;
  // Co/V are latched on the final RUN edge so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_r   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      co_r  <= 1'b0;
      v_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        a_sh  <= A;
        b_sh  <= Sub ? ~B : B;
        carry <= Sub;
        cnt   <= '0;
        co_r  <= 1'b0;
        v_r   <= 1'b0;
      end else if (state == RUN) begin
        s_r   <= {fa_s, s_r[WIDTH-1:1]};
        carry <= fa_co;
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        cnt   <= cnt + 1'b1;
        if (last) begin
          co_r <= fa_co;
          v_r  <= carry ^ fa_co;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_unit.sv
// tb_serial_adder_unit: directed and randomized checks of the serial adder at WIDTH 8 and 4.
module tb_serial_adder_unit;
  logic clk = 1'b0, rst = 1'b0;
  logic start8 = 1'b0, sub8 = 1'b0, busy8, done8, co8, v8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic start4 = 1'b0, sub4 = 1'b0, busy4, done4, co4, v4;
  logic [3:0] a4 = '0, b4 = '0, s4;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_adder_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Sub(sub8),
    .busy(busy8), .done(done8), .S(s8), .Co(co8), .V(v8)
  );
  serial_adder_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Sub(sub4),
    .busy(busy4), .done(done4), .S(s4), .Co(co4), .V(v4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b, input logic sub);
    if (w == 8) begin
      start8 = st; a8 = a; b8 = b; sub8 = sub;
    end else begin
      start4 = st; a4 = a[3:0]; b4 = b[3:0]; sub4 = sub;
    end
  endtask

  // Reference: plain modular arithmetic with signed-overflow rule on the effective operands.
  task automatic op(input int w, input logic [7:0] a, input logic [7:0] b, input logic sub, input bit inj);
    int mask, bp, sum, es, eco, ev, msb;
    logic ob, od;
    mask = (1 << w) - 1;
    bp   = sub ? (~int'(b) & mask) : (int'(b) & mask);
    sum  = (int'(a) & mask) + bp + int'(sub);
    es   = sum & mask;
    eco  = (sum >> w) & 1;
    msb  = w - 1;
    ev   = (((a >> msb) & 1) == ((bp >> msb) & 1)) && (((es >> msb) & 1) != ((a >> msb) & 1));
    @(negedge clk);
    drive(w, 1'b1, a, b, sub);
    @(posedge clk); #1;
    drive(w, 1'b0, a, b, sub);
    for (int k = 0; k < w; k++) begin
      ob = (w == 8) ? busy8 : busy4;
      od = (w == 8) ? done8 : done4;
      chk("busy_run", 32'(ob), 32'd1);
      chk("done_run", 32'(od), 32'd0);
      if (inj && k == 2) drive(w, 1'b1, 8'hAA, 8'h55, ~sub);
      @(posedge clk); #1;
      if (inj && k == 2) drive(w, 1'b0, 8'hAA, 8'h55, ~sub);
    end
    chk("done_pulse", 32'(w == 8 ? done8 : done4), 32'd1);
    chk("busy_done", 32'(w == 8 ? busy8 : busy4), 32'd0);
    chk("S", w == 8 ? 32'(s8) : 32'(s4), 32'(es));
    chk("Co", 32'(w == 8 ? co8 : co4), 32'(eco));
    chk("V", 32'(w == 8 ? v8 : v4), 32'(ev));
    @(posedge clk); #1;
    chk("done_once", 32'(w == 8 ? done8 : done4), 32'd0);
    chk("S_hold", w == 8 ? 32'(s8) : 32'(s4), 32'(es));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_S", 32'(s8), 32'd0);
    chk("rst_Co", 32'(co8), 32'd0);
    chk("rst_V", 32'(v8), 32'd0);
    op(8, 8'h05, 8'h03, 1'b0, 1'b0);
    op(8, 8'hFF, 8'h01, 1'b0, 1'b0);
    op(8, 8'h7F, 8'h01, 1'b0, 1'b0);
    op(8, 8'h03, 8'h05, 1'b1, 1'b0);
    op(8, 8'h80, 8'h01, 1'b1, 1'b0);
    op(8, 8'h10, 8'h20, 1'b0, 1'b1);
    chk("ignored_start_S", 32'(s8), 32'h30);
    // Abort an in-flight operation with reset.
    @(negedge clk);
    drive(8, 1'b1, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_S", 32'(s8), 32'd0);
    chk("abort_Co", 32'(co8), 32'd0);
    chk("abort_V", 32'(v8), 32'd0);
    for (int k = 0; k < 10; k++) begin
      chk("abort_no_done", 32'(done8), 32'd0);
      @(posedge clk); #1;
    end
    op(8, 8'h01, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++)
      op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op(4, 8'(a), 8'(b), 1'(s), 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
